// File: rtl/seg7_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_mux_pkg
// Brief  : Shared constants for the seven-segment scan multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
package seg7_scan_mux_pkg;

    localparam int           SEG7_NUM_DIGITS         = 8;
    localparam logic [7:0]   SEG7_AN_OFF             = 8'hFF;
    localparam logic         SEG7_DP_OFF             = 1'b1;
    localparam int           SEG7_DEF_TICKS_PER_DIGIT = 100000;
    localparam int           SEG7_DEF_GUARD_CYCLES    = 4;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_mux_if
// Brief  : Host load port and display-side outputs of the scan multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [3:0]                x;
    logic [NUM_DIGITS-1:0]     an;
    logic                      dp;
    logic                      blank;
    logic                      pending;
    logic                      frame_done;

    modport master (
        output load, value, dp_in, digit_en,
        input  x, an, dp, blank, pending, frame_done
    );

    modport slave (
        input  load, value, dp_in, digit_en,
        output x, an, dp, blank, pending, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux_slot_timer.sv
`default_nettype none
// ============================================================================
// Module : seg7_slot_timer
// Brief  : Per-digit slot counter with digit index wrap and guard window.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_slot_timer #(
    parameter int NUM_DIGITS      = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int GUARD_CYCLES    = 4,
    parameter int IDX_W           = 3,
    parameter int CNT_W           = 17
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic                  tick,
    output logic                  guard,
    output logic [IDX_W-1:0]      idx,
    output logic                  boundary
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] C_GUARD    = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_tick;

    assign w_tick   = (r_cnt == C_CNT_LAST);
    assign tick     = w_tick;
    assign guard    = (r_cnt < C_GUARD);
    assign idx      = r_idx;
    assign boundary = w_tick && (r_idx == C_IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module : seg7_scan_mux
// Brief  : 8-digit seven-segment scanner with tear-free shadowed updates.
//          Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Rev    : 1.0  initial release
// ============================================================================
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS      = SEG7_NUM_DIGITS,
    parameter int TICKS_PER_DIGIT = SEG7_DEF_TICKS_PER_DIGIT,
    parameter int GUARD_CYCLES    = SEG7_DEF_GUARD_CYCLES
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    seg7_scan_mux_if.slave  bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] C_AN_ONE = NUM_DIGITS'(1);

    logic                  w_tick;
    logic                  w_guard;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_boundary;
    logic                  w_frame_end;

    logic [VAL_W-1:0]      r_pd_value;
    logic [NUM_DIGITS-1:0] r_pd_dp;
    logic [NUM_DIGITS-1:0] r_pd_en;
    logic                  r_pending;
    logic [VAL_W-1:0]      r_sh_value;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [NUM_DIGITS-1:0] r_sh_en;

    logic                  w_lz_blank;
    logic                  w_dark;
    logic [3:0]            w_nibble;

    logic [3:0]            r_x;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_dp;
    logic                  r_blank;

    seg7_slot_timer #(
        .NUM_DIGITS      (NUM_DIGITS),
        .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
        .GUARD_CYCLES    (GUARD_CYCLES),
        .IDX_W           (IDX_W),
        .CNT_W           (CNT_W)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (w_tick),
        .guard    (w_guard),
        .idx      (w_idx),
        .boundary (w_boundary)
    );

    assign w_frame_end = w_tick && w_boundary;

    // A load landing on the frame boundary bypasses the pending regs entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pd_value <= '0;
            r_pd_dp    <= '0;
            r_pd_en    <= '0;
            r_pending  <= 1'b0;
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_en    <= '0;
        end else if (w_frame_end) begin
            r_pending <= 1'b0;
            if (bus.load) begin
                r_sh_value <= bus.value;
                r_sh_dp    <= bus.dp_in;
                r_sh_en    <= bus.digit_en;
            end else if (r_pending) begin
                r_sh_value <= r_pd_value;
                r_sh_dp    <= r_pd_dp;
                r_sh_en    <= r_pd_en;
            end
        end else if (bus.load) begin
            r_pd_value <= bus.value;
            r_pd_dp    <= bus.dp_in;
            r_pd_en    <= bus.digit_en;
            r_pending  <= 1'b1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    function automatic logic [IDX_W-1:0] top_nonzero(
        input logic [VAL_W-1:0]      v,
        input logic [NUM_DIGITS-1:0] en
    );
        logic [IDX_W-1:0] top;
        top = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en[i] && (v[4*i +: 4] != 4'h0)) begin
                top = IDX_W'(i);
            end
        end
        return top;
    endfunction

    logic [IDX_W-1:0] r_top_idx;

    // Highest nonzero index is frozen alongside the shadow data it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top_idx <= '0;
        end else if (w_frame_end) begin
            if (bus.load) begin
                r_top_idx <= top_nonzero(bus.value, bus.digit_en);
            end else if (r_pending) begin
                r_top_idx <= top_nonzero(r_pd_value, r_pd_en);
            end
        end
    end

    assign w_lz_blank = (w_idx > r_top_idx) && !r_sh_dp[w_idx];
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_nibble = r_sh_value[{w_idx, 2'b00} +: 4];
    assign w_dark   = w_guard || !r_sh_en[w_idx] || w_lz_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_an    <= '1;
            r_dp    <= SEG7_DP_OFF;
            r_blank <= 1'b1;
        end else begin
            r_x     <= w_nibble;
            r_an    <= w_dark ? '1 : ~(C_AN_ONE << w_idx);
            r_dp    <= w_dark ? SEG7_DP_OFF : ~r_sh_dp[w_idx];
            r_blank <= w_dark;
        end
    end

    assign bus.x          = r_x;
    assign bus.an         = r_an;
    assign bus.dp         = r_dp;
    assign bus.blank      = r_blank;
    assign bus.pending    = r_pending;
    assign bus.frame_done = w_frame_end;

endmodule
`default_nettype wire
